stg2id_hs: RTL and testbench

STG2ID_HS -- requirements
Module: stg2id_hs

---
 rtl/stg2id_hs.sv | 250 +++++++++++++++++++++++++
 tb/tb_stg2id_hs.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stg2id_hs.sv
// Fetch-to-decode handshake stage: decodes on the input side and holds up to
// two decoded entries (output register plus optional skid entry).
`ifndef STG2ID_ISA_DEFS
`define STG2ID_ISA_DEFS
`define SIZE_ADDR 16
`define SIZE_DATA 32
`define SIZE_OPC 6
`define SIZE_IMM 16
`define SIZE_CC 4
`define SIZE_GP 4
`define OPC_R_ADD    6'h00
`define OPC_R_SUB    6'h01
`define OPC_R_AND    6'h02
`define OPC_R_OR     6'h03
`define OPC_R_JCC    6'h04
`define OPC_R_BCC    6'h05
`define OPC_RS_ADDs  6'h08
`define OPC_RS_SUBs  6'h09
`define OPC_RS_SHRs  6'h0A
`define OPC_RS_CMPs  6'h0B
`define OPC_I_ADDi   6'h10
`define OPC_I_ANDi   6'h11
`define OPC_I_JCCi   6'h12
`define OPC_I_LD     6'h13
`define OPC_IS_ADDis 6'h18
`define OPC_IS_BCCis 6'h19
`define OPC_S_LUI    6'h20
`define OPC_S_SRJCC  6'h21
`endif

module stg2id_hs #(
    parameter int P_ADDR_W = `SIZE_ADDR,
    parameter int P_DATA_W = `SIZE_DATA,
    parameter int P_SKID   = 1,
    parameter int P_CNT_W  = 16
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_valid,
    output logic                 ow_ready,
    input  logic [P_ADDR_W-1:0]  iw_pc,
    input  logic [P_DATA_W-1:0]  iw_instr,
    input  logic                 iw_flush,
    output logic                 ow_valid,
    input  logic                 iw_ready,
    output logic [P_ADDR_W-1:0]  ow_pc,
    output logic [P_DATA_W-1:0]  ow_instr,
    output logic [`SIZE_OPC-1:0] ow_opc,
    output logic                 ow_sgn_en,
    output logic                 ow_imm_en,
    output logic [`SIZE_IMM-1:0] ow_imm_val,
    output logic [`SIZE_CC-1:0]  ow_cc,
    output logic [`SIZE_GP-1:0]  ow_tgt_gp,
    output logic                 ow_tgt_gp_we,
    output logic [`SIZE_GP-1:0]  ow_src_gp,
    output logic [P_CNT_W-1:0]   ow_stall_cnt
);

    // state   | meaning
    // S_EMPTY | nothing held, output is a bubble
    // S_ONE   | one entry in the output register
    // S_TWO   | output register plus skid entry (P_SKID=1 only)
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    typedef struct packed {
        logic [P_ADDR_W-1:0]  pc;
        logic [P_DATA_W-1:0]  instr;
        logic [`SIZE_OPC-1:0] opc;
        logic                 sgn_en;
        logic                 imm_en;
        logic [`SIZE_IMM-1:0] imm_val;
        logic [`SIZE_CC-1:0]  cc;
        logic [`SIZE_GP-1:0]  tgt_gp;
        logic                 tgt_gp_we;
        logic [`SIZE_GP-1:0]  src_gp;
    } entry_t;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    entry_t             r_out;
    entry_t             r_skid;
    entry_t             w_dec;
    entry_t             w_pres;
    logic [P_CNT_W-1:0] r_stall;
    logic               w_in;
    logic               w_out;
    logic               w_load_out;
    logic               w_load_skid;
    logic               w_promote;
    logic [`SIZE_GP-1:0]  w_f_tgt;
    logic [`SIZE_GP-1:0]  w_f_src;
    logic [`SIZE_IMM-1:0] w_f_imm;

    assign w_f_tgt = iw_instr[25:22];
    assign w_f_src = iw_instr[21:18];
    assign w_f_imm = iw_instr[15:0];

    // Unused fields stay zero so downstream never sees stale register indices.
    always_comb begin
        w_dec       = '0;
        w_dec.pc    = iw_pc;
        w_dec.instr = iw_instr;
        w_dec.opc   = iw_instr[31:26];
        case (iw_instr[31:26])
            `OPC_R_ADD, `OPC_R_SUB, `OPC_R_AND, `OPC_R_OR: begin
                w_dec.tgt_gp    = w_f_tgt;
                w_dec.tgt_gp_we = 1'b1;
                w_dec.src_gp    = w_f_src;
            end
            `OPC_R_JCC, `OPC_R_BCC: begin
                w_dec.cc     = w_f_tgt;
                w_dec.src_gp = w_f_src;
            end
            `OPC_RS_ADDs, `OPC_RS_SUBs, `OPC_RS_SHRs: begin
                w_dec.sgn_en    = 1'b1;
                w_dec.tgt_gp    = w_f_tgt;
                w_dec.tgt_gp_we = 1'b1;
                w_dec.src_gp    = w_f_src;
            end
            `OPC_RS_CMPs: begin
                w_dec.sgn_en = 1'b1;
                w_dec.src_gp = w_f_src;
            end
            `OPC_I_ADDi, `OPC_I_ANDi, `OPC_I_LD: begin
                w_dec.imm_en    = 1'b1;
                w_dec.imm_val   = w_f_imm;
                w_dec.tgt_gp    = w_f_tgt;
                w_dec.tgt_gp_we = 1'b1;
                w_dec.src_gp    = w_f_src;
            end
            `OPC_I_JCCi: begin
                w_dec.imm_en  = 1'b1;
                w_dec.imm_val = w_f_imm;
                w_dec.cc      = w_f_tgt;
                w_dec.src_gp  = w_f_src;
            end
            `OPC_IS_ADDis: begin
                w_dec.sgn_en    = 1'b1;
                w_dec.imm_en    = 1'b1;
                w_dec.imm_val   = w_f_imm;
                w_dec.tgt_gp    = w_f_tgt;
                w_dec.tgt_gp_we = 1'b1;
                w_dec.src_gp    = w_f_src;
            end
            `OPC_IS_BCCis: begin
                w_dec.sgn_en  = 1'b1;
                w_dec.imm_en  = 1'b1;
                w_dec.imm_val = w_f_imm;
                w_dec.cc      = w_f_tgt;
                w_dec.src_gp  = w_f_src;
            end
            `OPC_S_LUI: begin
                w_dec.imm_en    = 1'b1;
                w_dec.imm_val   = w_f_imm;
                w_dec.tgt_gp    = w_f_tgt;
                w_dec.tgt_gp_we = 1'b1;
            end
            `OPC_S_SRJCC: begin
                w_dec.cc = w_f_tgt;
            end
            default: ;
        endcase
    end

    assign ow_valid = (r_state != S_EMPTY);
    assign ow_ready = r_ready;
    assign w_in     = iw_valid && r_ready && !iw_flush;
    assign w_out    = ow_valid && iw_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_promote   = 1'b0;
        if (iw_flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in) begin
                        w_state_nxt = S_ONE;
                        w_load_out  = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in && w_out) begin
                        w_load_out = 1'b1;
                    end else if (w_in && (P_SKID != 0)) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out) begin
                        w_state_nxt = S_ONE;
                        w_promote   = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Ready is registered off the next state so it never depends on iw_ready.
    assign w_ready_nxt = (P_SKID != 0) ? (w_state_nxt != S_TWO) : (w_state_nxt == S_EMPTY);

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b1;
            r_out   <= '0;
            r_skid  <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            if (w_load_out) begin
                r_out <= w_dec;
            end else if (w_promote) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
            if (ow_valid && !iw_ready && (r_stall != '1)) begin
                r_stall <= r_stall + P_CNT_W'(1);
            end
        end
    end

    assign w_pres       = ow_valid ? r_out : '0;
    assign ow_pc        = w_pres.pc;
    assign ow_instr     = w_pres.instr;
    assign ow_opc       = w_pres.opc;
    assign ow_sgn_en    = w_pres.sgn_en;
    assign ow_imm_en    = w_pres.imm_en;
    assign ow_imm_val   = w_pres.imm_val;
    assign ow_cc        = w_pres.cc;
    assign ow_tgt_gp    = w_pres.tgt_gp;
    assign ow_tgt_gp_we = w_pres.tgt_gp_we;
    assign ow_src_gp    = w_pres.src_gp;
    assign ow_stall_cnt = r_stall;

endmodule

// File: tb/tb_stg2id_hs.sv
// Bench for stg2id_hs: a skid instance (k=0) and a single-entry, 4-bit counter
// instance (k=1), checked against a FIFO-count reference model.
`timescale 1ns/1ps
`ifndef STG2ID_ISA_DEFS
`define STG2ID_ISA_DEFS
`define SIZE_ADDR 16
`define SIZE_DATA 32
`define SIZE_OPC 6
`define SIZE_IMM 16
`define SIZE_CC 4
`define SIZE_GP 4
`define OPC_R_ADD    6'h00
`define OPC_R_SUB    6'h01
`define OPC_R_AND    6'h02
`define OPC_R_OR     6'h03
`define OPC_R_JCC    6'h04
`define OPC_R_BCC    6'h05
`define OPC_RS_ADDs  6'h08
`define OPC_RS_SUBs  6'h09
`define OPC_RS_SHRs  6'h0A
`define OPC_RS_CMPs  6'h0B
`define OPC_I_ADDi   6'h10
`define OPC_I_ANDi   6'h11
`define OPC_I_JCCi   6'h12
`define OPC_I_LD     6'h13
`define OPC_IS_ADDis 6'h18
`define OPC_IS_BCCis 6'h19
`define OPC_S_LUI    6'h20
`define OPC_S_SRJCC  6'h21
`endif

module tb_stg2id_hs;
    typedef struct packed {
        logic [5:0]  opc;
        logic        sgn;
        logic        imm_en;
        logic [15:0] imm;
        logic [3:0]  cc;
        logic [3:0]  tgt;
        logic        we;
        logic [3:0]  src;
    } dec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vin[2];
    logic        flush[2];
    logic        rdy[2];
    logic [15:0] pc_in[2];
    logic [31:0] ins_in[2];
    logic        o_valid[2];
    logic        o_ready[2];
    logic [15:0] o_pc[2];
    logic [31:0] o_instr[2];
    logic [5:0]  o_opc[2];
    logic        o_sgn[2];
    logic        o_imm_en[2];
    logic [15:0] o_imm[2];
    logic [3:0]  o_cc[2];
    logic [3:0]  o_tgt[2];
    logic        o_we[2];
    logic [3:0]  o_src[2];
    logic [15:0] o_cnt0;
    logic [3:0]  o_cnt1;

    int          m_n[2];
    logic [15:0] m_pc[2][2];
    logic [31:0] m_ins[2][2];
    logic        m_ready[2];
    int          m_stall[2];
    int          checks = 0;
    int          failures = 0;

    stg2id_hs #(.P_SKID(1), .P_CNT_W(16)) u_dut0 (
        .iw_clk(clk), .iw_rst(rst), .iw_valid(vin[0]), .ow_ready(o_ready[0]),
        .iw_pc(pc_in[0]), .iw_instr(ins_in[0]), .iw_flush(flush[0]),
        .ow_valid(o_valid[0]), .iw_ready(rdy[0]), .ow_pc(o_pc[0]), .ow_instr(o_instr[0]),
        .ow_opc(o_opc[0]), .ow_sgn_en(o_sgn[0]), .ow_imm_en(o_imm_en[0]),
        .ow_imm_val(o_imm[0]), .ow_cc(o_cc[0]), .ow_tgt_gp(o_tgt[0]),
        .ow_tgt_gp_we(o_we[0]), .ow_src_gp(o_src[0]), .ow_stall_cnt(o_cnt0)
    );

    stg2id_hs #(.P_SKID(0), .P_CNT_W(4)) u_dut1 (
        .iw_clk(clk), .iw_rst(rst), .iw_valid(vin[1]), .ow_ready(o_ready[1]),
        .iw_pc(pc_in[1]), .iw_instr(ins_in[1]), .iw_flush(flush[1]),
        .ow_valid(o_valid[1]), .iw_ready(rdy[1]), .ow_pc(o_pc[1]), .ow_instr(o_instr[1]),
        .ow_opc(o_opc[1]), .ow_sgn_en(o_sgn[1]), .ow_imm_en(o_imm_en[1]),
        .ow_imm_val(o_imm[1]), .ow_cc(o_cc[1]), .ow_tgt_gp(o_tgt[1]),
        .ow_tgt_gp_we(o_we[1]), .ow_src_gp(o_src[1]), .ow_stall_cnt(o_cnt1)
    );

    // Field usage expressed as opcode-class membership rules.
    function automatic dec_t exp_dec(input logic [31:0] ins);
        dec_t d;
        logic [5:0] op;
        logic is_r, is_rs, is_i, is_is, br, lui;
        op    = ins[31:26];
        is_r  = op inside {`OPC_R_ADD, `OPC_R_SUB, `OPC_R_AND, `OPC_R_OR, `OPC_R_JCC, `OPC_R_BCC};
        is_rs = op inside {`OPC_RS_ADDs, `OPC_RS_SUBs, `OPC_RS_SHRs, `OPC_RS_CMPs};
        is_i  = op inside {`OPC_I_ADDi, `OPC_I_ANDi, `OPC_I_JCCi, `OPC_I_LD};
        is_is = op inside {`OPC_IS_ADDis, `OPC_IS_BCCis};
        br    = op inside {`OPC_R_JCC, `OPC_R_BCC, `OPC_I_JCCi, `OPC_IS_BCCis, `OPC_S_SRJCC};
        lui   = (op == `OPC_S_LUI);
        d.opc    = op;
        d.sgn    = is_is || is_rs;
        d.imm_en = is_i || is_is || lui;
        d.imm    = d.imm_en ? ins[15:0] : 16'h0;
        d.cc     = br ? ins[25:22] : 4'h0;
        d.src    = (is_r || is_rs || is_i || is_is) ? ins[21:18] : 4'h0;
        d.we     = (is_r || is_rs || is_i || is_is || lui) && !br && (op != `OPC_RS_CMPs);
        d.tgt    = d.we ? ins[25:22] : 4'h0;
        return d;
    endfunction

    function automatic dec_t got_dec(input int k);
        dec_t d;
        d = '{o_opc[k], o_sgn[k], o_imm_en[k], o_imm[k], o_cc[k], o_tgt[k], o_we[k], o_src[k]};
        return d;
    endfunction

    function automatic int cnt(input int k);
        return (k == 0) ? int'(o_cnt0) : int'(o_cnt1);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops[18];
        logic [31:0] w;
        ops = '{`OPC_R_ADD, `OPC_R_SUB, `OPC_R_AND, `OPC_R_OR, `OPC_R_JCC, `OPC_R_BCC,
                `OPC_RS_ADDs, `OPC_RS_SUBs, `OPC_RS_SHRs, `OPC_RS_CMPs,
                `OPC_I_ADDi, `OPC_I_ANDi, `OPC_I_JCCi, `OPC_I_LD,
                `OPC_IS_ADDis, `OPC_IS_BCCis, `OPC_S_LUI, `OPC_S_SRJCC};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[31:26] = ops[$urandom_range(0, 17)];
        return w;
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUTs.
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_n[k] = 0; m_ready[k] = 1'b1; m_stall[k] = 0;
            end else begin
                bit acc, pop;
                acc = vin[k] && m_ready[k] && !flush[k];
                pop = (m_n[k] > 0) && rdy[k];
                if ((m_n[k] > 0) && !rdy[k] && (m_stall[k] < ((k == 0) ? 65535 : 15))) m_stall[k]++;
                if (flush[k]) begin
                    m_n[k] = 0;
                end else begin
                    if (pop) begin
                        m_pc[k][0] = m_pc[k][1]; m_ins[k][0] = m_ins[k][1]; m_n[k]--;
                    end
                    if (acc && m_n[k] < 2) begin
                        m_pc[k][m_n[k]] = pc_in[k]; m_ins[k][m_n[k]] = ins_in[k]; m_n[k]++;
                    end
                end
                m_ready[k] = (k == 0) ? (m_n[k] < 2) : (m_n[k] == 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b1; flush[k] = 1'b1; rdy[k] = 1'b0;
            pc_in[k] = 16'h55; ins_in[k] = rand_instr();
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_valid k=%0d got=%b exp=0", k, o_valid[k]); end
            checks++; if (o_ready[k] !== 1'b1) begin failures++; $display("FAIL reset_ready k=%0d got=%b exp=1", k, o_ready[k]); end
            checks++; if (cnt(k) != 0) begin failures++; $display("FAIL reset_cnt k=%0d got=%0d exp=0", k, cnt(k)); end
            checks++; if ({o_pc[k], o_instr[k], got_dec(k)} !== '0) begin failures++; $display("FAIL reset_data k=%0d got pc=%h ins=%h", k, o_pc[k], o_instr[k]); end
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin vin[k] = 1'b0; flush[k] = 1'b0; rdy[k] = 1'b1; end
    endtask

    task automatic test_addi();
        vin[0] = 1'b1; rdy[0] = 1'b1; pc_in[0] = 16'h0010;
        ins_in[0] = {`OPC_I_ADDi, 4'd3, 4'd2, 2'b00, 16'h1234};
        tick();
        vin[0] = 1'b0;
        checks++; if (o_valid[0] !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", o_valid[0]); end
        checks++; if (o_pc[0] !== 16'h0010) begin failures++; $display("FAIL addi_pc got=%h exp=0010", o_pc[0]); end
        checks++; if ({o_imm_en[0], o_sgn[0], o_we[0], o_cc[0], o_imm[0], o_tgt[0], o_src[0]} !== {1'b1, 1'b0, 1'b1, 4'h0, 16'h1234, 4'd3, 4'd2})
            begin failures++; $display("FAIL addi_dec got imm_en=%b sgn=%b we=%b cc=%h imm=%h", o_imm_en[0], o_sgn[0], o_we[0], o_cc[0], o_imm[0]); end
        tick();
        checks++; if (o_valid[0] !== 1'b0) begin failures++; $display("FAIL addi_bubble_valid got=%b exp=0", o_valid[0]); end
        checks++; if ({o_pc[0], o_instr[0], got_dec(0)} !== '0) begin failures++; $display("FAIL addi_bubble_zero got pc=%h ins=%h", o_pc[0], o_instr[0]); end
    endtask

    task automatic test_add_srjcc();
        vin[0] = 1'b1; rdy[0] = 1'b1; pc_in[0] = 16'h0030;
        ins_in[0] = {`OPC_R_ADD, 4'd5, 4'd7, 18'h3ABCD};
        tick();
        checks++; if ({o_src[0], o_cc[0], o_imm_en[0], o_tgt[0], o_we[0]} !== {4'd7, 4'h0, 1'b0, 4'd5, 1'b1})
            begin failures++; $display("FAIL add_dec got src=%h cc=%h imm_en=%b tgt=%h we=%b", o_src[0], o_cc[0], o_imm_en[0], o_tgt[0], o_we[0]); end
        pc_in[0] = 16'h0031;
        ins_in[0] = {`OPC_S_SRJCC, 4'hA, 4'h6, 18'h01234};
        tick();
        vin[0] = 1'b0;
        checks++; if ({o_pc[0], o_cc[0], o_we[0], o_src[0], o_tgt[0], o_imm_en[0]} !== {16'h0031, 4'hA, 1'b0, 4'h0, 4'h0, 1'b0})
            begin failures++; $display("FAIL srjcc_dec got pc=%h cc=%h we=%b src=%h tgt=%h", o_pc[0], o_cc[0], o_we[0], o_src[0], o_tgt[0]); end
        tick();
    endtask

    task automatic test_skid_stall();
        int s0;
        s0 = cnt(0);
        rdy[0] = 1'b0; vin[0] = 1'b1; pc_in[0] = 16'd1; ins_in[0] = rand_instr();
        tick();
        checks++; if ({o_valid[0], o_ready[0], o_pc[0]} !== {1'b1, 1'b1, 16'd1}) begin failures++; $display("FAIL skid_first got v=%b r=%b pc=%h", o_valid[0], o_ready[0], o_pc[0]); end
        pc_in[0] = 16'd2; ins_in[0] = rand_instr();
        tick();
        checks++; if (o_ready[0] !== 1'b0) begin failures++; $display("FAIL skid_full_ready got=%b exp=0", o_ready[0]); end
        pc_in[0] = 16'd3; ins_in[0] = rand_instr();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({o_pc[0], o_ready[0]} !== {16'd1, 1'b0}) begin failures++; $display("FAIL skid_hold i=%0d got pc=%h r=%b exp pc=0001 r=0", i, o_pc[0], o_ready[0]); end
        end
        checks++; if (cnt(0) != s0 + 4) begin failures++; $display("FAIL skid_stall_cnt got=%0d exp=%0d", cnt(0), s0 + 4); end
        rdy[0] = 1'b1;
        tick();
        checks++; if ({o_valid[0], o_pc[0], o_ready[0]} !== {1'b1, 16'd2, 1'b1}) begin failures++; $display("FAIL skid_drain2 got v=%b pc=%h r=%b", o_valid[0], o_pc[0], o_ready[0]); end
        tick();
        vin[0] = 1'b0;
        checks++; if ({o_valid[0], o_pc[0]} !== {1'b1, 16'd3}) begin failures++; $display("FAIL skid_drain3 got v=%b pc=%h exp pc=0003", o_valid[0], o_pc[0]); end
        tick();
        checks++; if (o_valid[0] !== 1'b0) begin failures++; $display("FAIL skid_empty got=%b exp=0", o_valid[0]); end
    endtask

    task automatic test_flush_two();
        rdy[0] = 1'b0; vin[0] = 1'b1;
        pc_in[0] = 16'h20; ins_in[0] = rand_instr(); tick();
        pc_in[0] = 16'h21; ins_in[0] = rand_instr(); tick();
        pc_in[0] = 16'h22; ins_in[0] = rand_instr(); flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0; vin[0] = 1'b0; rdy[0] = 1'b1;
        checks++; if ({o_valid[0], o_ready[0]} !== 2'b01) begin failures++; $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", o_valid[0], o_ready[0]); end
        checks++; if (cnt(0) != m_stall[0]) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", cnt(0), m_stall[0]); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({o_valid[0], o_pc[0]} !== 17'h0) begin failures++; $display("FAIL flush_ghost i=%0d got v=%b pc=%h", i, o_valid[0], o_pc[0]); end
        end
    endtask

    task automatic test_noskid_throughput();
        logic [15:0] nxt;
        int acc_n;
        bit acc;
        nxt = 16'h100; acc_n = 0;
        vin[1] = 1'b1; rdy[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_in[1] = nxt; ins_in[1] = rand_instr();
            acc = m_ready[1];
            checks++; if (o_ready[1] !== m_ready[1]) begin failures++; $display("FAIL noskid_ready i=%0d got=%b exp=%b", i, o_ready[1], m_ready[1]); end
            tick();
            if (acc) begin
                checks++; if ({o_valid[1], o_pc[1]} !== {1'b1, nxt}) begin failures++; $display("FAIL noskid_out i=%0d got v=%b pc=%h exp pc=%h", i, o_valid[1], o_pc[1], nxt); end
                nxt++; acc_n++;
            end else begin
                checks++; if (o_valid[1] !== 1'b0) begin failures++; $display("FAIL noskid_gap i=%0d got v=%b exp=0", i, o_valid[1]); end
            end
        end
        vin[1] = 1'b0;
        tick();
        checks++; if (acc_n != 10) begin failures++; $display("FAIL noskid_rate got=%0d exp=10", acc_n); end
    endtask

    task automatic test_stall_sat();
        vin[1] = 1'b1; rdy[1] = 1'b0; pc_in[1] = 16'h200; ins_in[1] = rand_instr();
        tick();
        vin[1] = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (o_cnt1 !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", o_cnt1); end
        checks++; if ({o_valid[1], o_pc[1]} !== {1'b1, 16'h200}) begin failures++; $display("FAIL sat_hold got v=%b pc=%h exp pc=0200", o_valid[1], o_pc[1]); end
        rst = 1'b1;
        tick();
        rst = 1'b0; rdy[1] = 1'b1;
        checks++; if ({o_cnt1, o_valid[1]} !== 5'h0) begin failures++; $display("FAIL sat_reset got cnt=%0d v=%b exp 0", o_cnt1, o_valid[1]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                vin[k]    = ($urandom_range(0, 9) < 7);
                rdy[k]    = ($urandom_range(0, 9) < 6);
                flush[k]  = ($urandom_range(0, 19) == 0);
                pc_in[k]  = 16'($urandom);
                ins_in[k] = rand_instr();
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++; if (o_valid[k] !== (m_n[k] > 0)) begin failures++; $display("FAIL rnd_valid c=%0d k=%0d got=%b exp=%0d", c, k, o_valid[k], m_n[k] > 0); end
                checks++; if (o_ready[k] !== m_ready[k]) begin failures++; $display("FAIL rnd_ready c=%0d k=%0d got=%b exp=%b", c, k, o_ready[k], m_ready[k]); end
                checks++; if (cnt(k) != m_stall[k]) begin failures++; $display("FAIL rnd_cnt c=%0d k=%0d got=%0d exp=%0d", c, k, cnt(k), m_stall[k]); end
                if (m_n[k] > 0) begin
                    checks++; if ({o_pc[k], o_instr[k]} !== {m_pc[k][0], m_ins[k][0]}) begin failures++; $display("FAIL rnd_entry c=%0d k=%0d got pc=%h ins=%h exp pc=%h ins=%h", c, k, o_pc[k], o_instr[k], m_pc[k][0], m_ins[k][0]); end
                    checks++; if (got_dec(k) !== exp_dec(m_ins[k][0])) begin failures++; $display("FAIL rnd_decode c=%0d k=%0d got=%h exp=%h", c, k, got_dec(k), exp_dec(m_ins[k][0])); end
                end else begin
                    checks++; if ({o_pc[k], o_instr[k], got_dec(k)} !== '0) begin failures++; $display("FAIL rnd_bubble c=%0d k=%0d got pc=%h ins=%h", c, k, o_pc[k], o_instr[k]); end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin vin[k] = 1'b0; flush[k] = 1'b0; rdy[k] = 1'b1; end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0; flush[k] = 1'b0; rdy[k] = 1'b1; pc_in[k] = '0; ins_in[k] = '0;
            m_n[k] = 0; m_ready[k] = 1'b1; m_stall[k] = 0;
        end
        test_reset();
        test_addi();
        test_add_srjcc();
        test_skid_stall();
        test_flush_two();
        test_noskid_throughput();
        test_stall_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
